// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the cacheline memory arbiter.
//   state_t : arbiter FSM states (idle, serving i-cache, serving d-cache)
//   gnt_t   : grant decision produced by the priority picker
//   ADDR_W_DEF / LINE_W_DEF : default address and cacheline widths
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int LINE_W_DEF = 256;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SERVE_I = 2'd1,
      S_SERVE_D = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_I    = 2'd1,
      GNT_D    = 2'd2
   } gnt_t;

endpackage

// File: rtl/mem_arb_checker.sv
// mem_arb_checker: simulation assertions for the memory arbiter.
// Ports:
//   clk, rst            : clock and asynchronous active-low reset
//   d_read, d_write     : d-cache request lines (must never both be high)
//   mem_read, mem_write : adaptor command lines (mutually exclusive)
module mem_arb_checker #(
   parameter int STARVE_LIMIT = 2
) (
   input logic clk,
   input logic rst,
   input logic d_read,
   input logic d_write,
   input logic mem_read,
   input logic mem_write
);

   // the d-cache may not request a read and a writeback at once
   a_no_d_rd_wr: assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write));

   // the adaptor is never commanded to read and write together
   a_no_mem_rd_wr: assert property (@(posedge clk) disable iff (!rst) !(mem_read && mem_write));

   // a zero starvation limit would let data outrank demand permanently
   a_limit_sane: assert property (@(posedge clk) disable iff (!rst) (STARVE_LIMIT >= 1));

endmodule

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: combinational priority picker for the memory arbiter.
// Ranking: instruction demand > data access > instruction prefetch.
// When starve is high, a waiting data access outranks instruction demand.
// Ports:
//   i_read, i_prefetch : i-cache request and prefetch qualifier
//   d_req              : d-cache read or writeback pending
//   starve             : data has been bypassed too often
//   gnt                : grant decision (gnt_t encoding)
module mem_arb_grant
   import mem_arb_pkg::*;
(
   input  logic       i_read,
   input  logic       i_prefetch,
   input  logic       d_req,
   input  logic       starve,
   output logic [1:0] gnt
);

   // priority selection among the three request classes
   always_comb begin
      gnt = GNT_NONE;
      if (d_req && starve) begin
         gnt = GNT_D;
      end else if (i_read && !i_prefetch) begin
         gnt = GNT_I;
      end else if (d_req) begin
         gnt = GNT_D;
      end else if (i_read) begin
         gnt = GNT_I;
      end else begin
         gnt = GNT_NONE;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the shared cacheline memory port between
// i-cache and d-cache misses. Priority: i demand > d access > i prefetch.
// Optional fairness: define MEM_ARB_FAIR_EN to let a data request win after
// STARVE_LIMIT consecutive instruction grants made while data waited.
// Ports:
//   clk, rst                     : clock, asynchronous active-low reset
//   i_read/i_prefetch/i_addr     : i-cache request (held until i_resp)
//   i_resp/i_rdata               : i-cache completion and line
//   d_read/d_write/d_addr/d_wdata: d-cache request (held until d_resp)
//   d_resp/d_rdata               : d-cache completion and line
//   mem_read/mem_write/mem_addr/mem_wdata : registered adaptor command
//   mem_rdata/mem_resp           : adaptor read line and completion
//   arbiter_instr_state          : high while serving the i-cache
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int LINE_W       = LINE_W_DEF,
   parameter int STARVE_LIMIT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic              i_prefetch,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_resp,
   output logic [LINE_W-1:0] i_rdata,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic              d_resp,
   output logic [LINE_W-1:0] d_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp,
   output logic              arbiter_instr_state
);

   state_t            state_r;
   logic [1:0]        gnt_s;
   logic              d_req_s;
   logic              starve_s;
   logic              mem_read_r;
   logic              mem_write_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [LINE_W-1:0] mem_wdata_r;
   logic              dir_r;
   logic              instr_r;

   assign d_req_s = d_read | d_write;

   mem_arb_grant u_grant (
      .i_read     (i_read),
      .i_prefetch (i_prefetch),
      .d_req      (d_req_s),
      .starve     (starve_s),
      .gnt        (gnt_s)
   );

`ifdef MEM_ARB_FAIR_EN
   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   logic [CNT_W-1:0] starve_cnt_r;

   // counts instruction grants that bypassed a waiting data request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == S_IDLE) && (gnt_s == GNT_D)) begin
         starve_cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == S_IDLE) && (gnt_s == GNT_I) && d_req_s && !starve_s) begin
         starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end else begin
         starve_cnt_r <= starve_cnt_r;
      end
   end

   assign starve_s = (starve_cnt_r == CNT_W'(STARVE_LIMIT));
`else
   assign starve_s = 1'b0;
`endif

   // arbiter FSM with registered adaptor command and status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= S_IDLE;
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= {LINE_W{1'b0}};
         dir_r       <= 1'b0;
         instr_r     <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               case (gnt_s)
                  GNT_I: begin
                     state_r    <= S_SERVE_I;
                     mem_read_r <= 1'b1;
                     mem_addr_r <= i_addr;
                     instr_r    <= 1'b1;
                  end
                  GNT_D: begin
                     // writeback wins if both d lines are (illegally) high
                     state_r     <= S_SERVE_D;
                     mem_addr_r  <= d_addr;
                     mem_wdata_r <= d_wdata;
                     dir_r       <= d_write;
                     mem_read_r  <= ~d_write;
                     mem_write_r <= d_write;
                  end
                  default: begin
                     state_r <= S_IDLE;
                  end
               endcase
            end
            S_SERVE_I: begin
               if (mem_resp) begin
                  state_r    <= S_IDLE;
                  mem_read_r <= 1'b0;
                  instr_r    <= 1'b0;
               end else begin
                  mem_read_r <= 1'b1;
               end
            end
            S_SERVE_D: begin
               if (mem_resp) begin
                  state_r     <= S_IDLE;
                  mem_read_r  <= 1'b0;
                  mem_write_r <= 1'b0;
               end else begin
                  mem_read_r  <= ~dir_r;
                  mem_write_r <= dir_r;
               end
            end
            default: begin
               state_r     <= S_IDLE;
               mem_read_r  <= 1'b0;
               mem_write_r <= 1'b0;
               instr_r     <= 1'b0;
            end
         endcase
      end
   end

   // completion pulses follow the adaptor response in the same cycle
   assign i_resp  = (state_r == S_SERVE_I) && mem_resp;
   assign d_resp  = (state_r == S_SERVE_D) && mem_resp;
   assign i_rdata = i_resp ? mem_rdata : {LINE_W{1'b0}};
   assign d_rdata = d_resp ? mem_rdata : {LINE_W{1'b0}};

   assign mem_read            = mem_read_r;
   assign mem_write           = mem_write_r;
   assign mem_addr            = mem_addr_r;
   assign mem_wdata           = mem_wdata_r;
   assign arbiter_instr_state = instr_r;

   mem_arb_checker #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_checker (
      .clk       (clk),
      .rst       (rst),
      .d_read    (d_read),
      .d_write   (d_write),
      .mem_read  (mem_read_r),
      .mem_write (mem_write_r)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         i_read = 1'b0, i_prefetch = 1'b0;
   logic [31:0]  i_addr = 32'd0;
   logic         i_resp;
   logic [255:0] i_rdata;
   logic         d_read = 1'b0, d_write = 1'b0;
   logic [31:0]  d_addr = 32'd0;
   logic [255:0] d_wdata = 256'd0;
   logic         d_resp;
   logic [255:0] d_rdata;
   logic         mem_read, mem_write;
   logic [31:0]  mem_addr;
   logic [255:0] mem_wdata;
   logic [255:0] mem_rdata = 256'd0;
   logic         mem_resp = 1'b0;
   logic         arbiter_instr_state;

   mem_arbiter #(.ADDR_W(32), .LINE_W(256), .STARVE_LIMIT(2)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_prefetch(i_prefetch), .i_addr(i_addr),
      .i_resp(i_resp), .i_rdata(i_rdata),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_resp(d_resp), .d_rdata(d_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .arbiter_instr_state(arbiter_instr_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           is_i;
      bit           wr;
      logic [31:0]  addr;
      logic [255:0] wdata;
      int           cyc;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   lat = 4;
   int   act_cnt = 0;
   int   i_burst = 0;
   bit   busy = 1'b0;
   bit   cur_i = 1'b0;
   bit   cur_w = 1'b0;
   bit   stray_resp = 1'b0;

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push(input bit is_i, input bit wr, input logic [31:0] a,
                       input logic [255:0] wd, input int c);
      exp_t e;
      e.is_i = is_i; e.wr = wr; e.addr = a; e.wdata = wd; e.cyc = c;
      q.push_back(e);
   endtask

   task automatic step();
      @(negedge clk);
      #3;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((q.size() != 0 || busy || i_read || d_read || d_write) && n < budget) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (n >= budget)
         check_val("idle_timeout", {q.size() != 0, busy, i_read, d_read, d_write}, 256'd0);
      step();
   endtask

   always @(posedge clk) cyc++;

   // adaptor model plus cache-side monitor and scoreboard consumer
   always @(negedge clk) begin : adaptor_mon
      exp_t e;
      logic act_now;
      if (!rst) begin
         busy = 1'b0;
         act_cnt = 0;
         mem_resp = 1'b0;
      end else begin
         act_now = mem_read | mem_write;
         if (act_now) check_val("rd_wr_excl", mem_read & mem_write, 256'd0);
         if (act_now && !busy) begin
            check_val("sb_has_entry", q.size() != 0, 256'd1);
            if (q.size() != 0) begin
               e = q.pop_front();
               check_val("start_kind", arbiter_instr_state, e.is_i);
               check_val("start_dir", mem_write, e.wr);
               check_val("start_addr", mem_addr, e.addr);
               if (e.wr) check_val("start_wdata", mem_wdata, e.wdata);
               check_val("start_cyc", cyc, e.cyc);
            end
            busy = 1'b1;
            act_cnt = 0;
            cur_i = arbiter_instr_state;
            cur_w = mem_write;
         end else if (act_now) begin
            check_val("hold_dir", mem_write, cur_w);
            check_val("hold_instr", arbiter_instr_state, cur_i);
         end else begin
            check_val("idle_instr", arbiter_instr_state, 256'd0);
         end
         mem_resp = stray_resp || (act_now && busy && act_cnt == lat - 1);
         if (mem_resp) mem_rdata = {8{$urandom}};
         #1;
         check_val("i_resp", i_resp, mem_resp && act_now && cur_i);
         check_val("d_resp", d_resp, mem_resp && act_now && !cur_i);
         if (i_resp) check_val("i_rdata", i_rdata, mem_rdata);
         if (d_resp) check_val("d_rdata", d_rdata, mem_rdata);
         if (mem_resp && act_now) begin
            busy = 1'b0;
            if (cur_i) begin
               if (i_burst > 0) begin
                  i_burst--;
                  i_addr = i_addr + 32'h40;
               end else begin
                  i_read = 1'b0;
                  i_prefetch = 1'b0;
               end
            end else begin
               d_read = 1'b0;
               d_write = 1'b0;
            end
         end
         act_cnt++;
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int c0;
      logic [255:0] wd;
      step();
      step();
      check_val("rst_mem_read", mem_read, 256'd0);
      check_val("rst_mem_write", mem_write, 256'd0);
      check_val("rst_i_resp", i_resp, 256'd0);
      check_val("rst_d_resp", d_resp, 256'd0);
      check_val("rst_instr", arbiter_instr_state, 256'd0);
      check_val("rst_mem_addr", mem_addr, 256'd0);
      check_val("rst_mem_wdata", mem_wdata, 256'd0);
      rst = 1'b1;
      step();

      // single i demand, latency 4
      lat = 4;
      c0 = cyc;
      i_read = 1'b1; i_prefetch = 1'b0; i_addr = 32'h0000_0040;
      push(1'b1, 1'b0, 32'h40, 256'd0, c0 + 1);
      wait_idle(200);

      // same-cycle i demand and d write: i first
      c0 = cyc;
      wd = {32{8'hA5}};
      i_read = 1'b1; i_addr = 32'h80;
      d_write = 1'b1; d_addr = 32'h100; d_wdata = wd;
      push(1'b1, 1'b0, 32'h80, 256'd0, c0 + 1);
      push(1'b0, 1'b1, 32'h100, wd, c0 + lat + 2);
      wait_idle(200);

      // same-cycle i prefetch and d read: d first
      c0 = cyc;
      i_read = 1'b1; i_prefetch = 1'b1; i_addr = 32'h200;
      d_read = 1'b1; d_addr = 32'h300;
      push(1'b0, 1'b0, 32'h300, 256'd0, c0 + 1);
      push(1'b1, 1'b0, 32'h200, 256'd0, c0 + lat + 2);
      wait_idle(200);

      // d read arriving one cycle after a prefetch grant waits for it
      lat = 5;
      c0 = cyc;
      i_read = 1'b1; i_prefetch = 1'b1; i_addr = 32'h240;
      push(1'b1, 1'b0, 32'h240, 256'd0, c0 + 1);
      step();
      d_read = 1'b1; d_addr = 32'h340;
      push(1'b0, 1'b0, 32'h340, 256'd0, c0 + lat + 2);
      wait_idle(200);

      // continuous i demands with a held d read
      lat = 3;
      c0 = cyc;
      i_burst = 3;
      i_read = 1'b1; i_prefetch = 1'b0; i_addr = 32'h400;
      d_read = 1'b1; d_addr = 32'h500;
`ifdef MEM_ARB_FAIR_EN
      push(1'b1, 1'b0, 32'h400, 256'd0, c0 + 1);
      push(1'b1, 1'b0, 32'h440, 256'd0, c0 + 1 + 1 * (lat + 1));
      push(1'b0, 1'b0, 32'h500, 256'd0, c0 + 1 + 2 * (lat + 1));
      push(1'b1, 1'b0, 32'h480, 256'd0, c0 + 1 + 3 * (lat + 1));
      push(1'b1, 1'b0, 32'h4C0, 256'd0, c0 + 1 + 4 * (lat + 1));
`else
      push(1'b1, 1'b0, 32'h400, 256'd0, c0 + 1);
      push(1'b1, 1'b0, 32'h440, 256'd0, c0 + 1 + 1 * (lat + 1));
      push(1'b1, 1'b0, 32'h480, 256'd0, c0 + 1 + 2 * (lat + 1));
      push(1'b1, 1'b0, 32'h4C0, 256'd0, c0 + 1 + 3 * (lat + 1));
      push(1'b0, 1'b0, 32'h500, 256'd0, c0 + 1 + 4 * (lat + 1));
`endif
      wait_idle(400);

      // asynchronous reset in the middle of a data writeback
      lat = 50;
      c0 = cyc;
      wd = {8{$urandom}};
      d_write = 1'b1; d_addr = 32'h600; d_wdata = wd;
      push(1'b0, 1'b1, 32'h600, wd, c0 + 1);
      step();
      step();
      step();
      check_val("pre_rst_write", mem_write, 256'd1);
      #1;
      rst = 1'b0;
      #1;
      check_val("async_rst_write", mem_write, 256'd0);
      check_val("async_rst_read", mem_read, 256'd0);
      check_val("async_rst_instr", arbiter_instr_state, 256'd0);
      d_write = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      check_val("post_rst_read", mem_read, 256'd0);
      check_val("post_rst_write", mem_write, 256'd0);
      check_val("post_rst_addr", mem_addr, 256'd0);
      check_val("post_rst_wdata", mem_wdata, 256'd0);
      check_val("post_rst_instr", arbiter_instr_state, 256'd0);
      stray_resp = 1'b1;
      step();
      stray_resp = 1'b0;
      check_val("stray_i_resp", i_resp, 256'd0);
      check_val("stray_d_resp", d_resp, 256'd0);
      check_val("stray_d_rdata", d_rdata, 256'd0);
      check_val("stray_i_rdata", i_rdata, 256'd0);
      step();
      check_val("stray_mem_read", mem_read, 256'd0);
      check_val("stray_mem_write", mem_write, 256'd0);

      // normal service resumes after reset
      lat = 2;
      c0 = cyc;
      i_read = 1'b1; i_prefetch = 1'b0; i_addr = 32'h0000_0700;
      push(1'b1, 1'b0, 32'h700, 256'd0, c0 + 1);
      wait_idle(200);

      check_val("sb_empty", q.size(), 256'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the shared cacheline memory port between instruction-cache and data-cache misses. It is the responder end of each cache's `read`/`resp` handshake and the initiator toward the cacheline adaptor. It ranks instruction demand fetches above data accesses, and data accesses above instruction prefetches. It exports the instruction-service state used by the cache performance counters.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width
- `LINE_W`, 256, cacheline width in bits
- `STARVE_LIMIT`, 2, consecutive instruction grants allowed while data waits; used only with fairness compiled in

Ports (one clock; reset is asynchronous and active-low):
- `clk  in  1  clock`
- `rst  in  1  asynchronous active-low reset`
- `i_read  in  1  i-cache line read request, held until i_resp`
- `i_prefetch  in  1  qualifies i_read as a prefetch, not a demand fetch`
- `i_addr  in  ADDR_W  i-cache line address`
- `i_resp  out  1  one-cycle completion to i-cache`
- `i_rdata  out  LINE_W  line returned to i-cache`
- `d_read  in  1  d-cache line read request, held until d_resp`
- `d_write  in  1  d-cache line writeback, held until d_resp`
- `d_addr  in  ADDR_W  d-cache line address`
- `d_wdata  in  LINE_W  writeback line`
- `d_resp  out  1  one-cycle completion to d-cache`
- `d_rdata  out  LINE_W  line returned to d-cache`
- `mem_read  out  1  adaptor read`
- `mem_write  out  1  adaptor write`
- `mem_addr  out  ADDR_W  registered address`
- `mem_wdata  out  LINE_W  registered write line`
- `mem_rdata  in  LINE_W  adaptor read line`
- `mem_resp  in  1  adaptor completion, one cycle`
- `arbiter_instr_state  out  1  high while in S_SERVE_I`

## Operation
- States:
  - `S_IDLE`: grant evaluated.
  - `S_SERVE_I`: instruction request outstanding.
  - `S_SERVE_D`: data request outstanding.
- Grant in S_IDLE, in priority order:
  1. `i_read & ~i_prefetch`
  2. `d_read | d_write`
  3. `i_read & i_prefetch`
  4. None: stay in S_IDLE.
- On grant:
  - Register `i_addr`/`d_addr` into `mem_addr`.
  - For a data grant, register `d_wdata` into `mem_wdata` and latch direction. `d_write` wins if both `d_read` and `d_write` are high; this case is illegal and flagged by a simulation assertion.
- S_SERVE_I: `mem_read`=1.
- S_SERVE_D: `mem_read`=~dir, `mem_write`=dir.
- On `mem_resp` in S_SERVE_x:
  - Pulse the matching `x_resp` combinationally in the same cycle.
  - Drive `x_rdata`=`mem_rdata` (passthrough, valid only during the resp cycle).
  - Next state S_IDLE.
- A granted prefetch is never aborted. Data waits until the prefetch's `mem_resp`.
- `mem_resp` outside a SERVE state is ignored.

## Timing
- Reset (asserted asynchronously, at any time including mid-transaction):
  - State S_IDLE.
  - `mem_read`, `mem_write`, `i_resp`, `d_resp`, `arbiter_instr_state` = 0.
  - `mem_addr`, `mem_wdata`, direction latch, starvation counter = 0.
  - An in-flight adaptor transaction is abandoned; the adaptor shares the reset.
- Request seen in S_IDLE at cycle 0 → `mem_read`/`mem_write` high at cycle 1.
- Adaptor response at cycle N → `x_resp` at N. Back in S_IDLE at N+1; a new grant is possible at N+1.
- Minimum turnaround: 2 cycles plus adaptor latency.
- S_IDLE is always occupied at least one cycle between transactions. A requester drops `read` the cycle after `resp`, so a stale request is never re-granted.
- Requests raised during a SERVE state wait; inputs are sampled only in S_IDLE.

## Configuration
- `MEM_ARB_FAIR_EN` defined:
  - A saturating counter increments on each instruction grant made while `d_read|d_write` is high.
  - It clears on each data grant.
  - When it equals `STARVE_LIMIT`, data outranks instruction demand for the next grant.
- Undefined: strict priority. No counter is generated.

## Structure
- `mem_arb_pkg`: state enum (`S_IDLE`, `S_SERVE_I`, `S_SERVE_D`), grant enum (`GNT_NONE`, `GNT_I`, `GNT_D`), `LINE_W`/`ADDR_W` defaults.
- One sub-module, `mem_arb_grant`: combinational priority/fairness picker producing the grant enum from requests and the starvation flag.
- The state register, address/data registers, and counter are in `mem_arbiter`.

## Test plan
- Single i demand, addr 0x0000_0040, adaptor latency 4:
  - `mem_read` cycles 1–4, `mem_addr`=0x40.
  - `i_resp` and `i_rdata`=`mem_rdata` at cycle 4.
  - `arbiter_instr_state`=1 cycles 1–4.
- Same-cycle i demand (0x80) and d write (0x100, data 0xA5…):
  - i granted first.
  - After its resp plus one S_IDLE cycle, `mem_write`=1 with `mem_addr`=0x100, `mem_wdata`=0xA5….
- Same-cycle i prefetch (0x200) and d read (0x300): d granted first; the prefetch follows.
- d read arrives one cycle after a prefetch grant: prefetch completes; d is granted the cycle after the S_IDLE return.
- `MEM_ARB_FAIR_EN`, `STARVE_LIMIT`=2, continuous i demands with d read held:
  - Third grant goes to d.
  - Without the macro, d waits until i demand drops.
- Reset pulled low mid S_SERVE_D:
  - `mem_write`=0 immediately.
  - After release: S_IDLE, all outputs 0, and a subsequent `mem_resp` is ignored.
